// File: rtl/stack_alu_pkg.sv
// Shared opcodes and FSM state encoding for the stack ALU sequencer.
// Used by stack_alu_sequencer and stack_seq_prog_mem.
package stack_alu_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } seq_state_e;

endpackage

// File: rtl/stack_seq_prog_mem.sv
// Program store: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module stack_seq_prog_mem #(
  parameter int n          = 8,
  parameter int PROG_DEPTH = 16,
  parameter int AW         = $clog2(PROG_DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [2:0]    wopcode,
  input  logic [n-1:0]  woperand,
  input  logic [AW-1:0] raddr,
  output logic [2:0]    ropcode,
  output logic [n-1:0]  roperand
);

  logic [2:0]   op_q  [PROG_DEPTH];
  logic [n-1:0] dat_q [PROG_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      op_q[waddr]  <= wopcode;
      dat_q[waddr] <= woperand;
    end
  end

  assign ropcode  = op_q[raddr];
  assign roperand = dat_q[raddr];

endmodule

// File: rtl/stack_alu_sequencer.sv
// Runs a short RPN program into a STACK_BASED_ALU and captures pops.
// Define STACK_SEQ_OVF_HALT_EN to stop issuing on the first overflow.
module stack_alu_sequencer
  import stack_alu_pkg::*;
#(
  parameter int n          = 8,
  parameter int PROG_DEPTH = 16,
  parameter int AW         = $clog2(PROG_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [2:0]    prog_opcode,
  input  logic [n-1:0]  prog_operand,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic [2:0]    alu_opcode,
  output logic [n-1:0]  alu_data,
  input  logic [n-1:0]  alu_result,
  input  logic          alu_overflow,
  output logic          result_valid,
  output logic [n-1:0]  result_data,
  output logic          overflow_flag
);

  seq_state_e    state_q, state_d;
  logic          start_q;
  logic [AW:0]   len_q;
  logic [AW-1:0] pc_q;
  logic          drain_q;
  logic [2:0]    st2_q;
  logic [2:0]    mem_op;
  logic [n-1:0]  mem_dat;
  logic          issue, last, cap_ovf, take_start;

  stack_seq_prog_mem #(
    .n(n), .PROG_DEPTH(PROG_DEPTH), .AW(AW)
  ) u_mem (
    .clk      (clk),
    .we       (prog_we && !busy),
    .waddr    (prog_addr),
    .wopcode  (prog_opcode),
    .woperand (prog_operand),
    .raddr    (pc_q),
    .ropcode  (mem_op),
    .roperand (mem_dat)
  );

  assign busy = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done = (state_q == S_DONE);
  assign take_start = (state_q == S_IDLE) && start && !start_q;
  assign last = ({1'b0, pc_q} + (AW+1)'(1)) == len_q;
  assign cap_ovf = ((st2_q == OP_ADD) || (st2_q == OP_MUL))
                   && alu_overflow;

  // start_q marks the launch cycle: edge 0 latches, edge 1 issues.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_q) begin
          if (len_q == '0) begin
            state_d = S_DONE;
          end else begin
            issue   = 1'b1;
            state_d = last ? S_DRAIN : S_RUN;
          end
        end
      end
      S_RUN: begin
`ifdef STACK_SEQ_OVF_HALT_EN
        if (cap_ovf) begin
          state_d = S_DRAIN;
        end else begin
          issue   = 1'b1;
          state_d = last ? S_DRAIN : S_RUN;
        end
`else
        issue   = 1'b1;
        state_d = last ? S_DRAIN : S_RUN;
`endif
      end
      S_DRAIN: if (drain_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      start_q       <= 1'b0;
      len_q         <= '0;
      pc_q          <= '0;
      drain_q       <= 1'b0;
      st2_q         <= OP_NOP;
      alu_opcode    <= OP_NOP;
      alu_data      <= '0;
      result_valid  <= 1'b0;
      result_data   <= '0;
      overflow_flag <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= take_start;
      drain_q    <= (state_q == S_DRAIN) ? !drain_q : 1'b0;
      alu_opcode <= issue ? mem_op  : OP_NOP;
      alu_data   <= issue ? mem_dat : '0;
      st2_q      <= alu_opcode;
      result_valid <= (st2_q == OP_POP);
      if (st2_q == OP_POP) result_data <= alu_result;
      if (take_start) begin
        len_q <= (prog_len > (AW+1)'(PROG_DEPTH))
                 ? (AW+1)'(PROG_DEPTH) : prog_len;
        pc_q          <= '0;
        overflow_flag <= 1'b0;
      end else begin
        if (issue)   pc_q          <= pc_q + AW'(1);
        if (cap_ovf) overflow_flag <= 1'b1;
      end
    end
  end

`ifdef STACK_SEQ_OVF_HALT_EN
  logic aborted_q;
  always_ff @(posedge clk) begin
    if (reset)                aborted_q <= 1'b0;
    else if (take_start)      aborted_q <= 1'b0;
    else if (busy && cap_ovf) aborted_q <= 1'b1;
  end
  assign aborted = aborted_q;
`else
  assign aborted = 1'b0;
`endif

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Directed bench for stack_alu_sequencer with a behavioural stack ALU.
// Expected values are hand-computed per program.
module tb_stack_alu_sequencer;
  import stack_alu_pkg::*;

  localparam int N  = 8;
  localparam int D  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [2:0]    prog_opcode;
  logic [N-1:0]  prog_operand;
  logic [AW:0]   prog_len;
  logic          start;
  logic          busy, done, aborted;
  logic [2:0]    alu_opcode;
  logic [N-1:0]  alu_data;
  logic [N-1:0]  alu_result;
  logic          alu_overflow;
  logic          result_valid;
  logic [N-1:0]  result_data;
  logic          overflow_flag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stack_alu_sequencer #(.n(N), .PROG_DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_opcode(prog_opcode), .prog_operand(prog_operand),
    .prog_len(prog_len), .start(start),
    .busy(busy), .done(done), .aborted(aborted),
    .alu_opcode(alu_opcode), .alu_data(alu_data),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .result_valid(result_valid), .result_data(result_data),
    .overflow_flag(overflow_flag)
  );

  // Behavioural stack ALU: registered result and overflow.
  logic signed [N-1:0]   stk [8];
  int                    sp;
  logic signed [N-1:0]   op_a, op_b, sum_v;
  logic signed [2*N-1:0] prod_v;

  always @(posedge clk) begin
    if (reset) begin
      sp <= 0;
      alu_result   <= '0;
      alu_overflow <= 1'b0;
    end else begin
      alu_overflow <= 1'b0;
      op_a = (sp >= 1) ? stk[sp-1] : '0;
      op_b = (sp >= 2) ? stk[sp-2] : '0;
      case (alu_opcode)
        OP_PUSH: begin
          stk[sp] <= alu_data;
          sp <= sp + 1;
        end
        OP_ADD: if (sp >= 2) begin
          sum_v = op_a + op_b;
          stk[sp-2] <= sum_v;
          sp <= sp - 1;
          alu_overflow <= (op_a[N-1] == op_b[N-1]) &&
                          (sum_v[N-1] != op_a[N-1]);
        end
        OP_MUL: if (sp >= 2) begin
          prod_v = op_a * op_b;
          stk[sp-2] <= prod_v[N-1:0];
          sp <= sp - 1;
          alu_overflow <= prod_v !=
            {{N{prod_v[N-1]}}, prod_v[N-1:0]};
        end
        OP_POP: if (sp >= 1) begin
          alu_result <= op_a;
          sp <= sp - 1;
        end
        default: ;
      endcase
    end
  end

  // Monitor: edge k is the k-th posedge after the one sampling start.
  int cyc = 0;
  int t0 = 0;
  int done_cnt, done_edge, rv_cnt, rv_edge, busy_edge;
  logic [N-1:0] rv_data;
  logic [2:0]   op1;
  logic [N-1:0] dat1;
  logic         op_seen;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    int e;
    e = cyc - t0 - 1;
    if (done) begin
      done_cnt++;
      done_edge = e;
    end
    if (result_valid) begin
      rv_cnt++;
      rv_edge = e;
      rv_data = result_data;
    end
    if (busy && busy_edge < 0) busy_edge = e;
    if (alu_opcode != OP_NOP) op_seen = 1'b1;
    if (e == 1) begin
      op1  = alu_opcode;
      dat1 = alu_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    done_cnt  = 0;
    done_edge = -1;
    rv_cnt    = 0;
    rv_edge   = -1;
    busy_edge = -1;
    rv_data   = '0;
    op1       = '0;
    dat1      = '0;
    op_seen   = 1'b0;
  endtask

  task automatic wr(input int a, input logic [2:0] op,
                    input logic [N-1:0] d);
    @(negedge clk);
    prog_we      = 1'b1;
    prog_addr    = AW'(a);
    prog_opcode  = op;
    prog_operand = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic load4(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [2:0] op);
    wr(0, OP_PUSH, a);
    wr(1, OP_PUSH, b);
    wr(2, op, '0);
    wr(3, OP_POP, '0);
  endtask

  task automatic run(input logic [AW:0] len, input bit inject,
                     output bit timed_out);
    clr_mon();
    @(negedge clk);
    prog_len = len;
    start    = 1'b1;
    t0       = cyc;
    @(negedge clk);
    start = 1'b0;
    if (inject) begin
      @(negedge clk);
      start        = 1'b1;
      prog_we      = 1'b1;
      prog_addr    = AW'(1);
      prog_opcode  = OP_PUSH;
      prog_operand = 8'd99;
      @(negedge clk);
      start   = 1'b0;
      prog_we = 1'b0;
    end
    for (int i = 0; i < 60; i++) begin
      if (done_cnt > 0) break;
      @(negedge clk);
    end
    timed_out = (done_cnt == 0);
    repeat (3) @(negedge clk);
  endtask

  bit to;
  logic exp_abort;

  initial begin
    reset = 1'b1; prog_we = 1'b0; prog_addr = '0;
    prog_opcode = '0; prog_operand = '0; prog_len = '0;
    start = 1'b0;
    clr_mon();
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_abort", aborted, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_ovf", overflow_flag, 0);
    chk("rst_op", alu_opcode, OP_NOP);
    chk("rst_data", alu_data, 0);
    chk("rst_rdata", result_data, 0);
    reset = 1'b0;

    for (int i = 0; i < D; i++) wr(i, OP_NOP, '0);

    // 7 + 15 = 22
    load4(8'd7, 8'd15, OP_ADD);
    run(5'd4, 1'b0, to);
    chk("add_timeout", to, 0);
    chk("add_done_cnt", done_cnt, 1);
    chk("add_done_edge", done_edge, 6);
    chk("add_rv_cnt", rv_cnt, 1);
    chk("add_rv_edge", rv_edge, 6);
    chk("add_rdata", rv_data, 8'h16);
    chk("add_ovf", overflow_flag, 0);
    chk("add_busy_edge", busy_edge, 1);
    chk("add_op1", op1, OP_PUSH);
    chk("add_dat1", dat1, 7);
    chk("add_busy_end", busy, 0);

    // 3 * 5 = 15
    load4(8'd3, 8'd5, OP_MUL);
    run(5'd4, 1'b0, to);
    chk("mul_timeout", to, 0);
    chk("mul_rdata", rv_data, 15);
    chk("mul_ovf", overflow_flag, 0);
    chk("mul_done_edge", done_edge, 6);

    // 100 + 100 overflows to 0xC8
    load4(8'd100, 8'd100, OP_ADD);
    run(5'd4, 1'b0, to);
`ifdef STACK_SEQ_OVF_HALT_EN
    exp_abort = 1'b1;
`else
    exp_abort = 1'b0;
`endif
    chk("ovf_timeout", to, 0);
    chk("ovf_rdata", rv_data, 8'hC8);
    chk("ovf_flag", overflow_flag, 1);
    chk("ovf_abort", aborted, exp_abort);

    // Empty program; start also clears the sticky flag
    run(5'd0, 1'b0, to);
    chk("len0_timeout", to, 0);
    chk("len0_done_cnt", done_cnt, 1);
    chk("len0_done_edge", done_edge, 1);
    chk("len0_op_seen", op_seen, 0);
    chk("len0_rv_cnt", rv_cnt, 0);
    chk("len0_ovf_clr", overflow_flag, 0);
    chk("len0_abort_clr", aborted, 0);

    // start/prog_we during RUN are ignored
    load4(8'd7, 8'd15, OP_ADD);
    run(5'd4, 1'b1, to);
    chk("inj_timeout", to, 0);
    chk("inj_done_cnt", done_cnt, 1);
    chk("inj_done_edge", done_edge, 6);
    chk("inj_rdata", rv_data, 8'h16);
    run(5'd4, 1'b0, to);
    chk("inj_mem_rdata", rv_data, 8'h16);

    // Length 20 clamps to 16 (entries 4..15 are NOP)
    load4(8'd3, 8'd5, OP_MUL);
    run(5'd20, 1'b0, to);
    chk("clamp_timeout", to, 0);
    chk("clamp_done_edge", done_edge, 18);
    chk("clamp_rv_cnt", rv_cnt, 1);
    chk("clamp_rdata", rv_data, 15);

    // Reset sampled at edge 3 of a 4-instruction run
    load4(8'd7, 8'd15, OP_ADD);
    clr_mon();
    @(negedge clk);
    prog_len = 5'd4;
    start    = 1'b1;
    t0       = cyc;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_busy", busy, 0);
    chk("mrst_op", alu_opcode, OP_NOP);
    chk("mrst_data", alu_data, 0);
    chk("mrst_rdata", result_data, 0);
    chk("mrst_rv", result_valid, 0);
    chk("mrst_ovf", overflow_flag, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("mrst_no_done", done_cnt, 0);
    chk("mrst_no_rv", rv_cnt, 0);
    run(5'd4, 1'b0, to);
    chk("post_timeout", to, 0);
    chk("post_done_edge", done_edge, 6);
    chk("post_rdata", rv_data, 8'h16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
